stat_accumulator: RTL and testbench

- Downstream of the sample-load datapath; consumes the stored x/y sample memories after loading completes.
- Reads the first n samples at one pair per clock and accumulates the four linear-regression moments: sum_x, sum_y, sum_xx and sum_xy.
- Delivers the moments to the coefficient stage with a done pulse.
- Start/done handshake with the top-level controller.

---
 rtl/stat_accumulator.sv | 84 ++++++++
 tb/tb_stat_accumulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stat_accumulator.sv
// stat_accumulator: streams n x/y sample pairs from memory and accumulates sum_x, sum_y, sum_xx, sum_xy.
// Ports: clk/rst (sync, active-low) | start, n_samples -> rd_addr, rd_en -> memories | inx, iny <- memories (1-cycle latency) | busy, done, sum_* results.
module stat_accumulator #(
  parameter int DW    = 20,
  parameter int DEPTH = 150,
  parameter int AW    = 8,
  parameter int GW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              n_samples,
  output logic [AW-1:0]              rd_addr,
  output logic                       rd_en,
  input  logic [DW-1:0]              inx,
  input  logic [DW-1:0]              iny,
  output logic                       busy,
  output logic                       done,
  output logic signed [DW+GW-1:0]    sum_x,
  output logic signed [DW+GW-1:0]    sum_y,
  output logic signed [2*DW+GW-1:0]  sum_xx,
  output logic signed [2*DW+GW-1:0]  sum_xy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [AW-1:0] n;
  logic vld;
  logic [AW-1:0] n_clamp;
  logic signed [DW-1:0] xs, ys;
  logic signed [2*DW-1:0] pxx, pxy;
  assign n_clamp = n_samples > AW'(DEPTH) ? AW'(DEPTH) : n_samples;
  assign xs = inx;
  assign ys = iny;
  assign pxx = (2*DW)'(xs) * (2*DW)'(xs);
  assign pxy = (2*DW)'(xs) * (2*DW)'(ys);
  assign busy = state == RUN || state == DRAIN;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      n       <= '0;
      rd_addr <= '0;
      rd_en   <= 1'b0;
      vld     <= 1'b0;
      done    <= 1'b0;
      sum_x   <= '0;
      sum_y   <= '0;
      sum_xx  <= '0;
      sum_xy  <= '0;
    end else begin
      vld  <= rd_en;
      done <= 1'b0;
      if (vld) begin
        sum_x  <= sum_x + (DW+GW)'(xs);
        sum_y  <= sum_y + (DW+GW)'(ys);
        sum_xx <= sum_xx + (2*DW+GW)'(pxx);
        sum_xy <= sum_xy + (2*DW+GW)'(pxy);
      end
      case (state)
        IDLE: if (start) begin
          n       <= n_clamp;
          rd_addr <= '0;
          sum_x   <= '0;
          sum_y   <= '0;
          sum_xx  <= '0;
          sum_xy  <= '0;
          rd_en   <= n_clamp != '0;
          done    <= n_clamp == '0;
          state   <= n_clamp == '0 ? DONE : RUN;
        end
        RUN: if (rd_addr == n - AW'(1)) begin
          rd_en <= 1'b0;
          state <= DRAIN;
        end else begin
          rd_addr <= rd_addr + AW'(1);
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stat_accumulator.sv
// tb_stat_accumulator: scoreboard bench for stat_accumulator with a memory model and plain-arithmetic reference.
module tb_stat_accumulator;
  localparam int DW = 20, DEPTH = 150, AW = 8, GW = 8;
  logic clk = 0, rst = 0, start = 0;
  logic [AW-1:0] n_samples = '0, rd_addr;
  logic rd_en, busy, done;
  logic [DW-1:0] inx = '0, iny = '0;
  logic signed [DW+GW-1:0] sum_x, sum_y;
  logic signed [2*DW+GW-1:0] sum_xx, sum_xy;
  logic signed [DW-1:0] mx [DEPTH], my [DEPTH];
  typedef struct {
    longint sx, sy, sxx, sxy;
    int n, t0, lat;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, cyc = 0, exp_addr = 0, rd_cnt = 0;

  stat_accumulator #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .GW(GW)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .rd_addr(rd_addr), .rd_en(rd_en), .inx(inx), .iny(iny),
    .busy(busy), .done(done), .sum_x(sum_x), .sum_y(sum_y),
    .sum_xx(sum_xx), .sum_xy(sum_xy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en && int'(rd_addr) < DEPTH) begin
    inx <= mx[rd_addr];
    iny <= my[rd_addr];
  end

  task automatic chk(input string name, input longint got, input longint want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_en) begin
      chk("rd_addr", longint'(rd_addr), longint'(exp_addr));
      exp_addr++;
      rd_cnt++;
    end
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("sum_x", longint'(sum_x), e.sx);
        chk("sum_y", longint'(sum_y), e.sy);
        chk("sum_xx", longint'(sum_xx), e.sxx);
        chk("sum_xy", longint'(sum_xy), e.sxy);
        chk("read_count", longint'(rd_cnt), longint'(e.n));
        chk("latency", longint'(cyc - e.t0), longint'(e.lat));
      end
    end
    if (!busy) begin
      exp_addr = 0;
      rd_cnt = 0;
    end
  end

  task automatic issue(input int nreq);
    exp_t e;
    e.n = nreq > DEPTH ? DEPTH : nreq;
    e.sx = 0; e.sy = 0; e.sxx = 0; e.sxy = 0;
    for (int i = 0; i < e.n; i++) begin
      e.sx  += longint'(mx[i]);
      e.sy  += longint'(my[i]);
      e.sxx += longint'(mx[i]) * longint'(mx[i]);
      e.sxy += longint'(mx[i]) * longint'(my[i]);
    end
    e.lat = e.n == 0 ? 0 : e.n + 1;
    @(negedge clk);
    start = 1;
    n_samples = AW'(nreq);
    @(posedge clk);
    #1;
    start = 0;
    e.t0 = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_rd_en", longint'(rd_en), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_sum_xx", longint'(sum_xx), 0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < DEPTH; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      mx[i] = DW'(i + 1);
      my[i] = DW'(2 * (i + 1));
    end
    issue(4);
    wait_done();
    chk("basic_sum_xy", longint'(sum_xy), 60);
    issue(0);
    wait_done();
    chk("zero_sum_x", longint'(sum_x), 0);
    for (int i = 0; i < DEPTH; i++) begin
      mx[i] = 1;
      my[i] = 1;
    end
    issue(200);
    wait_done();
    for (int i = 0; i < DEPTH; i++) begin
      mx[i] = -20'sd524288;
      my[i] = -20'sd524288;
    end
    issue(150);
    wait_done();
    chk("bound_sum_xx", longint'(sum_xx), 64'd41231686041600);
    mx[0] = -3; mx[1] = 5; my[0] = 7; my[1] = -2;
    issue(2);
    wait_done();
    chk("mixed_sum_xy", longint'(sum_xy), -31);
    issue(10);
    repeat (3) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    q.delete();
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_rd_en", longint'(rd_en), 0);
    chk("midrst_sum_x", longint'(sum_x), 0);
    chk("midrst_sum_xy", longint'(sum_xy), 0);
    @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      mx[i] = DW'($urandom);
      my[i] = DW'($urandom);
    end
    issue(8);
    repeat (3) @(negedge clk);
    start = 1;
    n_samples = 2;
    @(negedge clk);
    start = 0;
    wait_done();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mx[i] = DW'($urandom);
        my[i] = DW'($urandom);
      end
      issue(t == 0 ? 150 : int'($urandom_range(0, 255)));
      wait_done();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
